alu_arbiter: RTL

//  Shares the single registered-output ALU between NREQ requesters, e.g. decode/issue and a

---
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one registered-output ALU between
//               NREQ requesters. Each operation runs latch -> issue -> wait ->
//               respond, so exactly one operation is ever in flight. A WAIT
//               watchdog turns a silent ALU into an error response.
//               Optional feature macro: ALU_ARB_DIV0_TRAP_EN (divide or
//               remainder by zero is answered locally with an error).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WIDTH-1:0]         req_a,
  input  logic [NREQ*WIDTH-1:0]         req_b,
  input  logic [NREQ*(WIDTH-27)-1:0]    req_op,
  output logic [NREQ-1:0]               resp_valid,
  input  logic [NREQ-1:0]               resp_ready,
  output logic [WIDTH-1:0]              resp_data,
  output logic                          resp_err,
  output logic                          alu_en,
  output logic [WIDTH-1:0]              alu_port_A,
  output logic [WIDTH-1:0]              alu_port_B,
  output logic [WIDTH-28:0]             alu_operation,
  input  logic [WIDTH-1:0]              alu_data_out,
  input  logic                          alu_valid
);

  localparam int OPW = WIDTH - 27;
  localparam int GW  = $clog2(NREQ);
  localparam int CW  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_last;
  logic [GW-1:0]     r_gnt;
  logic [CW-1:0]     r_cnt;
  logic              r_trap;

  logic              w_any;
  logic [GW-1:0]     w_gnt;
  int                w_idx;
  logic              w_accept;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic [OPW-1:0]    w_sel_op;
  logic              w_trap;
  logic [NREQ-1:0]   w_gnt_oh;

  // Round-robin search: first pending requester after the last one served.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = GW'(w_idx);
      end
    end
  end

  // Acceptance is suppressed while reset is applied so nothing is consumed
  // by an operation that reset is about to discard.
  assign w_accept = (r_state == S_IDLE) && w_any && !rst;

  assign w_sel_a  = req_a[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_sel_b  = req_b[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_sel_op = req_op[int'(w_gnt)*OPW +: OPW];

  assign w_gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;

`ifdef ALU_ARB_DIV0_TRAP_EN
  localparam logic [OPW-1:0] c_OP_DIV = OPW'(8);
  localparam logic [OPW-1:0] c_OP_REM = OPW'(9);
  assign w_trap = ((w_sel_op == c_OP_DIV) || (w_sel_op == c_OP_REM)) && (w_sel_b == '0);
`else
  assign w_trap = 1'b0;
`endif

  // One-hot accept strobe decoded from the IDLE arbitration result.
  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_gnt] = 1'b1;
    end
  end

  // Operation sequencer; every output except req_ready is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last        <= GW'(NREQ - 1);
      r_gnt         <= '0;
      r_cnt         <= '0;
      r_trap        <= 1'b0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      alu_en        <= 1'b0;
      alu_port_A    <= '0;
      alu_port_B    <= '0;
      alu_operation <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt         <= w_gnt;
            alu_port_A    <= w_sel_a;
            alu_port_B    <= w_sel_b;
            alu_operation <= w_sel_op;
            r_trap        <= w_trap;
            // Enable is registered at accept so it is high during ISSUE;
            // a trapped operation never reaches the ALU.
            alu_en        <= !w_trap;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_en <= 1'b0;
          r_cnt  <= '0;
          if (r_trap) begin
            resp_data  <= '1;
            resp_err   <= 1'b1;
            resp_valid <= w_gnt_oh;
            r_state    <= S_RESP;
          end else begin
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (alu_valid) begin
            resp_data  <= alu_data_out;
            resp_err   <= 1'b0;
            resp_valid <= w_gnt_oh;
            r_state    <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_cnt      <= r_cnt + 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= w_gnt_oh;
            r_state    <= S_RESP;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready[r_gnt]) begin
            resp_valid <= '0;
            r_last     <= r_gnt;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
